// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests, buffers responses for decode.
// Optional build macro IFETCH_PERF_CNT_EN adds pop and stall performance counters.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_next_o
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o
`endif
);
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned SW  = CW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q;
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [AW-1:0] fifo_rd_q, fifo_wr_q;
    logic [CW-1:0] fifo_cnt_q;
    logic [31:0]   infl_pc_q    [DEPTH];
    logic [AW-1:0] infl_rd_q, infl_wr_q;
    logic [CW-1:0] outst_q, drop_q;

    logic          grant, fifo_push, fifo_pop, fifo_full;
    logic [SW-1:0] credit_used;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    // Outstanding includes words still to be dropped; a same-cycle pop frees a slot for full throughput.
    assign credit_used = SW'(fifo_cnt_q) + SW'(outst_q) - SW'(fifo_pop);
    assign imem_req_o  = reset && !redirect_i && (credit_used < SW'(DEPTH));
    assign imem_addr_o = pc_q;
    assign grant       = imem_req_o && imem_gnt_i;

    assign valid_o   = (fifo_cnt_q != '0);
    assign fifo_full = (fifo_cnt_q == CW'(DEPTH));
    assign fifo_pop  = valid_o && !stall_i && !redirect_i;
    assign fifo_push = imem_rvalid_i && (drop_q == '0) && !redirect_i;

    assign instr_o   = valid_o ? fifo_instr_q[fifo_rd_q] : NOP;
    assign pc_o      = valid_o ? fifo_pc_q[fifo_rd_q] : 32'd0;
    assign pc_next_o = pc_o + 32'd4;

    // Control state; redirect overrides every other event in its cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_cnt_q <= '0;
            infl_rd_q  <= '0;
            infl_wr_q  <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            if (redirect_i) begin
                pc_q       <= {redirect_pc_i[31:2], 2'b00};
                fifo_rd_q  <= '0;
                fifo_wr_q  <= '0;
                fifo_cnt_q <= '0;
                outst_q    <= outst_q - CW'(imem_rvalid_i);
                drop_q     <= outst_q - CW'(imem_rvalid_i);
            end else begin
                if (grant) pc_q <= pc_q + 32'd4;
                if (fifo_push) fifo_wr_q <= fifo_wr_q + AW'(1);
                if (fifo_pop) fifo_rd_q <= fifo_rd_q + AW'(1);
                fifo_cnt_q <= fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
                outst_q    <= outst_q + CW'(grant) - CW'(imem_rvalid_i);
                if (imem_rvalid_i && (drop_q != '0)) drop_q <= drop_q - CW'(1);
            end
            // In-flight PC queue tracks every response, dropped or not.
            if (grant) infl_wr_q <= infl_wr_q + AW'(1);
            if (imem_rvalid_i) infl_rd_q <= infl_rd_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (grant) infl_pc_q[infl_wr_q] <= pc_q;
        if (fifo_push) begin
            fifo_instr_q[fifo_wr_q] <= imem_rdata_i;
            fifo_pc_q[fifo_wr_q]    <= infl_pc_q[infl_rd_q];
        end
    end

    assert property (@(posedge clk) disable iff (!reset) !(fifo_push && fifo_full && !fifo_pop))
        else $error("ifetch_stage: push into full FIFO");

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (fifo_pop) perf_fetch_q <= perf_fetch_q + 32'd1;
            if (stall_i && valid_o && !redirect_i) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule
